lab5_2_rr_arbiter: RTL and testbench

LAB5_2_RR_ARBITER -- requirements
Module: lab5_2_rr_arbiter

---
 rtl/lab5_2_rr_arbiter.sv | 90 +++++++++
 tb/tb_lab5_2_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab5_2_rr_arbiter.sv
// Four-source round-robin arbiter feeding a single registered output beat.
// The last-granted pointer rotates priority so every held request is served within four loads.
module lab5_2_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        ack,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
  output logic [7:0]        xfer_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_sel;
  logic [1:0]        r_lg;
  logic [7:0]        r_cnt;

  logic              w_xfer;
  logic              w_load;
  logic [1:0]        w_win;
  logic              w_found;
  logic [DATA_W-1:0] w_data;

  assign w_xfer = r_valid & out_ready;
  // Reset gates the load so ack stays quiet while rst is high.
  assign w_load = ~rst & (~r_valid | out_ready) & (|req);

  always_comb begin
    logic [1:0] idx;
    w_win   = r_lg;
    w_found = 1'b0;
    idx     = r_lg;
    for (int k = 1; k <= 4; k++) begin
      idx = r_lg + 2'(k);
      if (!w_found && req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = in0;
    case (w_win)
      2'd0: w_data = in0;
      2'd1: w_data = in1;
      2'd2: w_data = in2;
      2'd3: w_data = in3;
      default: w_data = in0;
    endcase
  end

  assign ack = w_load ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_lg    <= 2'd3;
      r_cnt   <= 8'd0;
    end else begin
      if (w_xfer) r_cnt <= r_cnt + 8'd1;
      // A load in a transfer cycle replaces the beat that just left.
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_sel   <= w_win;
        r_lg    <= w_win;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign sel       = r_sel;
  assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_lab5_2_rr_arbiter.sv
// Self-checking bench for lab5_2_rr_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_lab5_2_rr_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] in0, in1, in2, in3;
  logic [3:0]   ack;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   sel;
  logic [7:0]   xfer_cnt;

  lab5_2_rr_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .ack(ack), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .sel(sel), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_sel = 0;
  int           m_lg = 3;
  int           m_cnt = 0;
  logic [3:0]   e_ack;
  int           e_w;

  function automatic logic [W-1:0] src(int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  task automatic model_ack();
    e_w = -1;
    e_ack = 4'b0000;
    if (!rst && (!m_valid || out_ready))
      for (int k = 1; k <= 4; k++)
        if (e_w < 0 && req[(m_lg + k) % 4]) e_w = (m_lg + k) % 4;
    if (e_w >= 0) e_ack = 4'(1 << e_w);
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic rdy);
    rst = r; req = q; out_ready = rdy;
    #1;
    model_ack();
  endtask

  task automatic tick();
    logic         nv;
    logic [W-1:0] nd;
    int           ns, nl, nc;
    model_ack();
    nv = m_valid; nd = m_data; ns = m_sel; nl = m_lg; nc = m_cnt;
    if (rst) begin
      nv = 1'b0; nd = '0; ns = 0; nl = 3; nc = 0;
    end else begin
      if (m_valid && out_ready) nc = (m_cnt + 1) % 256;
      if (e_w >= 0) begin
        nv = 1'b1; nd = src(e_w); ns = e_w; nl = e_w;
      end else if (m_valid && out_ready) begin
        nv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_data = nd; m_sel = ns; m_lg = nl; m_cnt = nc;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'hF, 1'b1);
    n_total++;
    if (ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack);
    else n_pass++;
    tick();
    n_total++;
    if ({out_valid, out_data, sel, xfer_cnt} !== {1'b0, 8'h00, 2'd0, 8'd0})
      $display("FAIL reset_state: got v=%b d=%h s=%0d c=%0d want all zero", out_valid, out_data, sel, xfer_cnt);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [W-1:0] exp_d [4];
    exp_d[0] = 8'hAA; exp_d[1] = 8'hB1; exp_d[2] = 8'hC2; exp_d[3] = 8'hD3;
    in0 = 8'hAA; in1 = 8'hB1; in2 = 8'hC2; in3 = 8'hD3;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'hF, 1'b1);
      n_total++;
      if (ack !== 4'(1 << (i % 4)) || ack !== e_ack)
        $display("FAIL rotate_ack[%0d]: got %b want %b", i, ack, 4'(1 << (i % 4)));
      else n_pass++;
      tick();
      n_total++;
      if (sel !== 2'(i % 4) || out_data !== exp_d[i % 4] || out_valid !== 1'b1)
        $display("FAIL rotate_out[%0d]: got s=%0d d=%h v=%b want s=%0d d=%h v=1", i, sel, out_data, out_valid, i % 4, exp_d[i % 4]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 4'b0100, 1'b1);
    n_total++;
    if (ack !== 4'b0100) $display("FAIL stall_load_ack: got %b want 0100", ack);
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1011, 1'b0);
      n_total++;
      if (ack !== 4'b0000) $display("FAIL stall_ack[%0d]: got %b want 0000", i, ack);
      else n_pass++;
      tick();
      n_total++;
      if (sel !== 2'd2 || out_data !== 8'hC2 || out_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: got s=%0d d=%h v=%b want s=2 d=C2 v=1", i, sel, out_data, out_valid);
      else n_pass++;
    end
    drive(1'b0, 4'b1011, 1'b1);
    n_total++;
    if (ack !== 4'b1000) $display("FAIL stall_release_ack: got %b want 1000", ack);
    else n_pass++;
    tick();
    n_total++;
    if (sel !== 2'd3 || out_data !== 8'hD3)
      $display("FAIL stall_release_out: got s=%0d d=%h want s=3 d=D3", sel, out_data);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1'b0, 4'b0100, 1'b1);
    n_total++;
    if (ack !== 4'b0100) $display("FAIL wrap_ack2: got %b want 0100", ack);
    else n_pass++;
    tick();
    drive(1'b0, 4'b0001, 1'b1);
    n_total++;
    if (ack !== 4'b0001) $display("FAIL wrap_ack0: got %b want 0001", ack);
    else n_pass++;
    tick();
    n_total++;
    if (sel !== 2'd0 || out_data !== 8'hAA)
      $display("FAIL wrap_out: got s=%0d d=%h want s=0 d=AA", sel, out_data);
    else n_pass++;
  endtask

  task automatic test_drain();
    drive(1'b1, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 4'b0010, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 1'b1);
    n_total++;
    if (ack !== 4'b0000) $display("FAIL drain_ack: got %b want 0000", ack);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || out_data !== 8'hB1 || sel !== 2'd1 || xfer_cnt !== 8'd1)
      $display("FAIL drain_out: got v=%b d=%h s=%0d c=%0d want v=0 d=B1 s=1 c=1", out_valid, out_data, sel, xfer_cnt);
    else n_pass++;
  endtask

  task automatic test_cnt_wrap();
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 4'hF, 1'b1);
      tick();
    end
    n_total++;
    if (xfer_cnt !== 8'd255) $display("FAIL cnt_255: got %0d want 255", xfer_cnt);
    else n_pass++;
    drive(1'b0, 4'b0000, 1'b1);
    tick();
    n_total++;
    if (xfer_cnt !== 8'd0 || out_valid !== 1'b0)
      $display("FAIL cnt_wrap: got c=%0d v=%b want c=0 v=0", xfer_cnt, out_valid);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    drive(1'b0, 4'b0100, 1'b1);
    tick();
    drive(1'b0, 4'b0100, 1'b0);
    tick();
    drive(1'b1, 4'b0100, 1'b0);
    n_total++;
    if (ack !== 4'b0000) $display("FAIL midrst_ack: got %b want 0000", ack);
    else n_pass++;
    tick();
    n_total++;
    if ({out_valid, out_data, sel, xfer_cnt} !== {1'b0, 8'h00, 2'd0, 8'd0})
      $display("FAIL midrst_state: got v=%b d=%h s=%0d c=%0d want all zero", out_valid, out_data, sel, xfer_cnt);
    else n_pass++;
    drive(1'b0, 4'b0110, 1'b1);
    n_total++;
    if (ack !== 4'b0010) $display("FAIL midrst_first_ack: got %b want 0010", ack);
    else n_pass++;
    tick();
    n_total++;
    if (sel !== 2'd1 || out_data !== 8'hB1)
      $display("FAIL midrst_first_out: got s=%0d d=%h want s=1 d=B1", sel, out_data);
    else n_pass++;
  endtask

  task automatic test_random();
    int wait0 = 0;
    for (int i = 0; i < 400; i++) begin
      in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
      drive(($urandom_range(0, 39) == 0), {3'($urandom), 1'b1}, 1'($urandom_range(0, 2) != 0));
      n_total++;
      if (ack !== e_ack || $countones(ack) > 1)
        $display("FAIL rand_ack[%0d]: got %b want %b", i, ack, e_ack);
      else n_pass++;
      if (rst) wait0 = 0;
      else if (ack != 4'b0000) wait0 = ack[0] ? 0 : wait0 + 1;
      n_total++;
      if (wait0 > 3) $display("FAIL rand_fair[%0d]: source 0 passed over %0d loads, bound 3", i, wait0);
      else n_pass++;
      tick();
      n_total++;
      if ({out_valid, out_data, sel, xfer_cnt} !== {m_valid, m_data, 2'(m_sel), 8'(m_cnt)})
        $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d c=%0d want v=%b d=%h s=%0d c=%0d",
                 i, out_valid, out_data, sel, xfer_cnt, m_valid, m_data, m_sel, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    in0 = 8'hAA; in1 = 8'hB1; in2 = 8'hC2; in3 = 8'hD3;
    @(posedge clk);
    #1;
    test_reset();
    test_rotation();
    test_stall();
    test_wrap();
    test_drain();
    test_cnt_wrap();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
